// File: rtl/radix4_booth_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, exact 2N-bit product.
// Build option RADIX4_MUL_ZERO_BYPASS_EN: a zero operand completes at the start edge.
module radix4_booth_multiplier #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signedInput,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p,
    output logic           done,
    output logic           busy,
    output logic [1:0]     state_dbg
);
    localparam int W  = N + 1;
    localparam int E  = W + (W % 2);
    localparam int K  = E / 2;
    localparam int MW = W + 1;
    localparam int AW = W + 2 + E;
    localparam int CW = $clog2(K + 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Handshake: start (with x, y, signedInput) is accepted only in IDLE or DONE;
    // busy is high for the K iteration cycles; done is a level that holds p
    // until the next accepted start or reset.

    logic [1:0]           state_q, state_d;
    logic signed [MW-1:0] x_q, x_d;
    logic [E-1:0]         y_q, y_d;
    logic                 yprev_q, yprev_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*N-1:0]       p_q, p_d;

    logic signed [MW-1:0] x_dbl;
    logic signed [MW-1:0] mult;
    logic signed [AW-1:0] sum;
    logic                 x_sgn;
    logic                 y_sgn;
`ifdef RADIX4_MUL_ZERO_BYPASS_EN
    logic                 zero_op;
`endif

    always_comb begin
        x_dbl = x_q <<< 1;
        mult  = '0;
        case ({y_q[1:0], yprev_q})
            3'b001, 3'b010: mult = x_q;
            3'b011:         mult = x_dbl;
            3'b100:         mult = -x_dbl;
            3'b101, 3'b110: mult = -x_q;
            default:        mult = '0;
        endcase
        // Multiple is added at the top of the accumulator, then the whole thing shifts down.
        sum = acc_q + {{(AW - MW - E){mult[MW-1]}}, mult, {E{1'b0}}};
    end

    always_comb begin
        x_sgn   = signedInput & x[N-1];
        y_sgn   = signedInput & y[N-1];
`ifdef RADIX4_MUL_ZERO_BYPASS_EN
        zero_op = (x == '0) || (y == '0);
`endif
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        yprev_d = yprev_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = {x_sgn, x_sgn, x};
                    y_d     = {{(E - N){y_sgn}}, y};
                    yprev_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef RADIX4_MUL_ZERO_BYPASS_EN
                    if (zero_op) begin
                        p_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                acc_d   = sum >>> 2;
                y_d     = {2'b00, y_q[E-1:2]};
                yprev_d = y_q[1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    p_d     = acc_d[2*N-1:0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            yprev_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            yprev_q <= yprev_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign p         = p_q;
    assign done      = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Directed bench for radix4_booth_multiplier at N=8 (K=5 Booth digits).
// Expectations follow RADIX4_MUL_ZERO_BYPASS_EN when it is defined.
module tb_radix4_booth_multiplier;
    localparam int N = 8;
    localparam int K = 5;
`ifdef RADIX4_MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signedInput;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] p;
    logic           done;
    logic           busy;
    logic [1:0]     state_dbg;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [2*N-1:0] exp_q[$];
    int             gap_q[$];
    logic [N-1:0]   opx_q[$];
    logic [N-1:0]   opy_q[$];
    logic           ops_q[$];

    radix4_booth_multiplier #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signedInput (signedInput),
        .x           (x),
        .y           (y),
        .p           (p),
        .done        (done),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference product from plain integer arithmetic
    function automatic logic [15:0] ref_mul(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        int          ia;
        int          ib;
        logic [31:0] pr;
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        pr = 32'(ia * ib);
        return pr[15:0];
    endfunction

    // Driver tasks
    task automatic start_op(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start       = 1'b1;
        signedInput = sgn;
        x           = a;
        y           = b;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bcnt);
        start_op(sgn, a, b);
        wait_done(lat, bcnt);
    endtask

    task automatic apply_op(input int i);
        start       = 1'b1;
        signedInput = ops_q[i];
        x           = opx_q[i];
        y           = opy_q[i];
        exp_q.push_back(ref_mul(ops_q[i], opx_q[i], opy_q[i]));
        gap_q.push_back((BYP && (opx_q[i] == 0 || opy_q[i] == 0)) ? 1 : K + 1);
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signedInput = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        n_asserts++; if (p !== 16'h0000) begin n_fail++; $display("FAIL reset_p: got %h want 0000", p); end
        n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_asserts++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %b want %b", state_dbg, ST_IDLE); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_asserts++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_unsigned_max();
        int lat, bcnt;
        run_op(1'b0, 8'd255, 8'd255, lat, bcnt);
        n_asserts++; if (lat != K) begin n_fail++; $display("FAIL umax_latency: got %0d want %0d", lat, K); end
        n_asserts++; if (bcnt != K) begin n_fail++; $display("FAIL umax_busy_cycles: got %0d want %0d", bcnt, K); end
        n_asserts++; if (p !== 16'hFE01) begin n_fail++; $display("FAIL umax_p: got %h want fe01", p); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL umax_busy_at_done: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        n_asserts++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b want 1", done); end
        n_asserts++; if (p !== 16'hFE01) begin n_fail++; $display("FAIL hold_p: got %h want fe01", p); end
        n_asserts++; if (state_dbg !== ST_DONE) begin n_fail++; $display("FAIL hold_state: got %b want %b", state_dbg, ST_DONE); end
    endtask

    task automatic test_signed_corners();
        logic        t_s[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0]  t_a[8] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h80};
        logic [7:0]  t_b[8] = '{8'h80, 8'h7F, 8'h01, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h01};
        logic [15:0] t_p[8] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h00FF,
                                16'h0001, 16'h3F01, 16'h4000, 16'hFF80};
        int lat, bcnt;
        for (int i = 0; i < 8; i++) begin
            run_op(t_s[i], t_a[i], t_b[i], lat, bcnt);
            n_asserts++; if (p !== t_p[i]) begin n_fail++; $display("FAIL corner_p[%0d] s=%b %h*%h: got %h want %h", i, t_s[i], t_a[i], t_b[i], p, t_p[i]); end
            n_asserts++; if (lat != K) begin n_fail++; $display("FAIL corner_latency[%0d]: got %0d want %0d", i, lat, K); end
        end
    endtask

    task automatic test_zero_operand();
        int lat, bcnt;
        int exp_lat;
        exp_lat = BYP ? 0 : K;
        run_op(1'b0, 8'd37, 8'd0, lat, bcnt);
        n_asserts++; if (p !== 16'h0000) begin n_fail++; $display("FAIL zero_y_p: got %h want 0000", p); end
        n_asserts++; if (lat != exp_lat) begin n_fail++; $display("FAIL zero_y_latency: got %0d want %0d", lat, exp_lat); end
        n_asserts++; if (bcnt != exp_lat) begin n_fail++; $display("FAIL zero_y_busy_cycles: got %0d want %0d", bcnt, exp_lat); end
        run_op(1'b0, 8'd200, 8'd200, lat, bcnt);
        run_op(1'b1, 8'd0, 8'h9C, lat, bcnt);
        n_asserts++; if (p !== 16'h0000) begin n_fail++; $display("FAIL zero_x_p: got %h want 0000", p); end
        n_asserts++; if (lat != exp_lat) begin n_fail++; $display("FAIL zero_x_latency: got %0d want %0d", lat, exp_lat); end
    endtask

    task automatic test_start_while_busy();
        int lat, bcnt;
        start_op(1'b0, 8'd12, 8'd13);
        @(negedge clk);
        start = 1'b1; x = 8'd200; y = 8'd200;
        @(negedge clk);
        start = 1'b0; x = 8'd99; y = 8'd77;
        wait_done(lat, bcnt);
        n_asserts++; if (lat + 2 != K) begin n_fail++; $display("FAIL busy_start_latency: got %0d want %0d", lat + 2, K); end
        n_asserts++; if (p !== 16'h009C) begin n_fail++; $display("FAIL busy_start_p: got %h want 009c", p); end
        repeat (2) @(negedge clk);
        n_asserts++; if (done !== 1'b1 || p !== 16'h009C) begin n_fail++; $display("FAIL busy_start_stale: done %b p %h want 1 009c", done, p); end
        run_op(1'b0, 8'd200, 8'd200, lat, bcnt);
        n_asserts++; if (p !== 16'h9C40) begin n_fail++; $display("FAIL done_start_p: got %h want 9c40", p); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        start_op(1'b0, 8'd100, 8'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_asserts++; if (p !== 16'h0000) begin n_fail++; $display("FAIL midrst_p: got %h want 0000", p); end
        n_asserts++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_asserts++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %b want %b", state_dbg, ST_IDLE); end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 8'd100, 8'd3, lat, bcnt);
        n_asserts++; if (p !== 16'h012C) begin n_fail++; $display("FAIL post_rst_p: got %h want 012c", p); end
        n_asserts++; if (lat != K) begin n_fail++; $display("FAIL post_rst_latency: got %0d want %0d", lat, K); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]     vals[12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h25, 8'h55,
                                     8'h7F, 8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};
        logic [2*N-1:0] e;
        int             eg, gap, got, idx, total;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 12; i++)
                for (int j = 0; j < 12; j++) begin
                    ops_q.push_back(s == 1);
                    opx_q.push_back(vals[i]);
                    opy_q.push_back(vals[j]);
                end
        total = ops_q.size();
        got   = 0;
        gap   = 0;
        @(negedge clk);
        apply_op(0);
        idx = 1;
        while (got < total) begin
            @(negedge clk);
            gap++;
            if (gap > 40) begin
                n_asserts++; n_fail++;
                $display("FAIL b2b_timeout: no done after %0d cycles at result %0d", gap, got);
                break;
            end
            if (done === 1'b1) begin
                e  = exp_q.pop_front();
                eg = gap_q.pop_front();
                n_asserts++; if (p !== e) begin n_fail++; $display("FAIL b2b_p[%0d]: got %h want %h", got, p, e); end
                n_asserts++; if (gap != eg) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d want %0d", got, gap, eg); end
                got++;
                gap = 0;
                if (idx < total) begin
                    apply_op(idx);
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_zero_operand();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
